// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS front end: word width, PC step, NOP encoding,
// fetch FSM states and the {PC+4, instruction} entry carried to the IF/ID register.
package cpu_pkg;

    localparam int unsigned WORD_W = 32;
    localparam logic [WORD_W-1:0] PC_INC = 32'd4;
    localparam logic [WORD_W-1:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } fetch_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] added_pc;
        logic [WORD_W-1:0] inst;
    } fetch_entry_t;

    // Modulo-2^32 increment; 32'hFFFF_FFFC wraps to 0.
    function automatic logic [WORD_W-1:0] pc_next(input logic [WORD_W-1:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry ordered buffer (out slot + skid) between instruction memory and IF/ID.
// Empty entries read as {0, NOP} so the consumer never sees stale data.
module fetch_skid_buf
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] NOP_INST = cpu_pkg::NOP_INST
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         accept_i,
    input  logic         flush_i,
    output fetch_entry_t out_o,
    output logic         valid_o,
    output logic         full_o
);

    fetch_entry_t out_q, out_d;
    fetch_entry_t skid_q, skid_d;
    logic         out_vld_q, out_vld_d;
    logic         skid_vld_q, skid_vld_d;
    fetch_entry_t empty_entry;

    assign empty_entry = '{added_pc: '0, inst: NOP_INST};

    always_comb begin
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;

        if (flush_i) begin
            out_d      = empty_entry;
            out_vld_d  = 1'b0;
            skid_d     = empty_entry;
            skid_vld_d = 1'b0;
        end else if (!out_vld_q || accept_i) begin
            // Out slot frees up: the older skid entry goes first, new data backfills.
            if (skid_vld_q) begin
                out_d      = skid_q;
                out_vld_d  = 1'b1;
                skid_d     = push_i ? push_data_i : empty_entry;
                skid_vld_d = push_i;
            end else begin
                out_d     = push_i ? push_data_i : empty_entry;
                out_vld_d = push_i;
            end
        end else if (push_i) begin
            skid_d     = push_data_i;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q      <= empty_entry;
            out_vld_q  <= 1'b0;
            skid_q     <= empty_entry;
            skid_vld_q <= 1'b0;
        end else begin
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign out_o   = out_q;
    assign valid_o = out_vld_q;
    assign full_o  = skid_vld_q;

endmodule

// File: rtl/if_fetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, fetches over a req/ack handshake and
// delivers {PC+4, instruction} to IF/ID, honouring stalls and branch/jump redirects.
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [WORD_W-1:0] NOP_INST = cpu_pkg::NOP_INST
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              branch_i,
    input  logic [WORD_W-1:0] branch_target_i,
    input  logic              jump_i,
    input  logic [WORD_W-1:0] jump_target_i,
    output logic              imem_req_o,
    output logic [WORD_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [WORD_W-1:0] imem_rdata_i,
    output logic [WORD_W-1:0] addedPC_o,
    output logic [WORD_W-1:0] inst_o,
    output logic              inst_valid_o
);

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic              pend_q, pend_d;

    logic              redirect;
    logic [WORD_W-1:0] redirect_pc;
    logic              ack;
    logic              req;
    logic              accept;
    logic              push;
    logic              flush;
    fetch_entry_t      push_data;
    fetch_entry_t      out_entry;
    logic              out_valid;
    logic              skid_full;

    assign redirect    = branch_i | jump_i;
    assign redirect_pc = jump_i ? jump_target_i : branch_target_i;
    // An ack only means something while a request is outstanding.
    assign ack         = imem_ack_i & pend_q;
    // Once raised, req stays up until ack even if the skid fills meanwhile.
    assign req         = (state_q == FETCH) & (pend_q | ~skid_full);
    assign accept      = out_valid & ~stall_i;
    assign push_data   = '{added_pc: pc_next(pc_q), inst: imem_rdata_i};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        push    = 1'b0;
        flush   = 1'b0;

        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (ack) begin
                    pend_d = 1'b0;
                    if (!redirect) begin
                        pc_d = pc_next(pc_q);
                        push = 1'b1;
                    end
                end else begin
                    pend_d = req;
                    // The in-flight fetch belongs to the old path; wait out its ack.
                    if (redirect && req) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (ack) begin
                    pend_d  = 1'b0;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
                pend_d  = 1'b0;
            end
        endcase

        if (redirect) begin
            pc_d  = redirect_pc;
            flush = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
        end
    end

    fetch_skid_buf #(
        .NOP_INST (NOP_INST)
    ) u_skid_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_data_i (push_data),
        .accept_i    (accept),
        .flush_i     (flush),
        .out_o       (out_entry),
        .valid_o     (out_valid),
        .full_o      (skid_full)
    );

    assign imem_req_o   = req;
    assign imem_addr_o  = pc_q;
    assign addedPC_o    = out_entry.added_pc;
    assign inst_o       = out_entry.inst;
    assign inst_valid_o = out_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: a latency-programmable memory model feeds a scoreboard of
// expected {PC+4, inst} pairs that the consumer side pops on every accepted slot.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [31:0] XOR_K    = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch;
    logic [31:0] branch_tgt;
    logic        jump;
    logic [31:0] jump_tgt;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] added_pc;
    logic [31:0] inst;
    logic        valid;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .stall_i         (stall),
        .branch_i        (branch),
        .branch_target_i (branch_tgt),
        .jump_i          (jump),
        .jump_target_i   (jump_tgt),
        .imem_req_o      (req),
        .imem_addr_o     (addr),
        .imem_ack_i      (ack),
        .imem_rdata_i    (rdata),
        .addedPC_o       (added_pc),
        .inst_o          (inst),
        .inst_valid_o    (valid)
    );

    int          n_checks  = 0;
    int          n_pass    = 0;
    int          delivered = 0;
    int          lat       = 1;
    int          cnt       = 0;
    bit          busy      = 1'b0;
    bit          kill      = 1'b0;
    logic [31:0] addr_l;
    logic [31:0] exp_pc    = RESET_PC;
    logic [63:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    // Consumer, then memory, in one process so queue updates are ordered.
    always @(negedge clk) begin
        logic        redir;
        logic [31:0] tgt;
        logic [63:0] e;
        redir = branch | jump;
        tgt   = jump ? jump_tgt : branch_tgt;
        if (rst) begin
            busy   = 1'b0;
            kill   = 1'b0;
            ack    = 1'b0;
            exp_pc = RESET_PC;
            exp_q.delete();
        end else begin
            if (valid && !stall && !redir) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_valid", {31'b0, valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("added_pc", added_pc, e[63:32]);
                    check_eq("inst", inst, e[31:0]);
                    delivered++;
                end
            end
            ack = 1'b0;
            if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    ack   = 1'b1;
                    rdata = addr_l ^ XOR_K;
                    busy  = 1'b0;
                    if (!kill && !redir) begin
                        exp_q.push_back({exp_pc + 32'd4, exp_pc ^ XOR_K});
                        exp_pc = exp_pc + 32'd4;
                    end
                end
            end else if (req) begin
                check_eq("req_addr", addr, exp_pc);
                addr_l = addr;
                busy   = 1'b1;
                cnt    = lat;
                kill   = 1'b0;
            end
            if (redir) begin
                exp_q.delete();
                exp_pc = tgt;
                if (busy) kill = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        stall  = 1'b0;
        branch = 1'b0;
        jump   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_deliv(input int n, input int budget, input string tag);
        int i = 0;
        while (delivered < n && i < budget) begin
            tick();
            i++;
        end
        check_eq(tag, delivered, n);
    endtask

    task automatic wait_req(input logic [31:0] a, input string tag);
        int i = 0;
        while (!(req === 1'b1 && addr === a) && i < 80) begin
            tick();
            i++;
        end
        check_eq(tag, {31'b0, (req === 1'b1 && addr === a)}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        stall      = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        branch_tgt = 32'h0;
        jump_tgt   = 32'h0;
        ack        = 1'b0;
        rdata      = 32'h0;
        lat        = 1;

        // 1: reset state, one IDLE cycle, then first request at RESET_PC.
        tick();
        @(negedge clk);
        check_eq("rst_req", {31'b0, req}, 32'd0);
        check_eq("rst_valid", {31'b0, valid}, 32'd0);
        check_eq("rst_inst", inst, NOP);
        check_eq("rst_added_pc", added_pc, 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_req", {31'b0, req}, 32'd0);
        tick();
        @(negedge clk);
        check_eq("first_req", {31'b0, req}, 32'd1);
        check_eq("first_addr", addr, RESET_PC);
        check_eq("first_valid", {31'b0, valid}, 32'd0);

        // 2: streaming, no stall.
        wait_deliv(3, 40, "t2_deliv");

        // 3: stall fills out slot and skid, req drops; release drains in order.
        do_reset();
        stall     = 1'b1;
        delivered = 0;
        repeat (8) tick();
        @(negedge clk);
        check_eq("t3_req_blocked", {31'b0, req}, 32'd0);
        check_eq("t3_hold_valid", {31'b0, valid}, 32'd1);
        check_eq("t3_hold_inst", inst, 32'hA5A5_0000);
        check_eq("t3_hold_added_pc", added_pc, 32'd4);
        tick();
        stall = 1'b0;
        wait_deliv(3, 40, "t3_deliv");

        // 4: branch while the 0x8 fetch is outstanding with a slow memory -> DRAIN.
        do_reset();
        lat = 3;
        wait_req(32'h8, "t4_req8");
        branch     = 1'b1;
        branch_tgt = 32'h100;
        tick();
        branch    = 1'b0;
        delivered = 0;
        @(negedge clk);
        check_eq("t4_drain_req", {31'b0, req}, 32'd0);
        check_eq("t4_flush_valid", {31'b0, valid}, 32'd0);
        check_eq("t4_flush_inst", inst, NOP);
        check_eq("t4_flush_added_pc", added_pc, 32'd0);
        wait_req(32'h100, "t4_req100");
        wait_deliv(2, 60, "t4_deliv");

        // 5: jump and branch together, coincident with an ack; jump wins.
        do_reset();
        lat = 2;
        wait_req(32'h8, "t5_req8");
        tick();
        tick();
        jump       = 1'b1;
        jump_tgt   = 32'h400;
        branch     = 1'b1;
        branch_tgt = 32'h200;
        tick();
        jump      = 1'b0;
        branch    = 1'b0;
        delivered = 0;
        @(negedge clk);
        check_eq("t5_req", {31'b0, req}, 32'd1);
        check_eq("t5_addr", addr, 32'h400);
        check_eq("t5_valid", {31'b0, valid}, 32'd0);
        wait_deliv(2, 60, "t5_deliv");

        // 6: reset while stalled with the skid full.
        do_reset();
        lat   = 1;
        stall = 1'b1;
        repeat (8) tick();
        @(negedge clk);
        check_eq("t6_full_req", {31'b0, req}, 32'd0);
        check_eq("t6_full_valid", {31'b0, valid}, 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        check_eq("t6_rst_req", {31'b0, req}, 32'd0);
        check_eq("t6_rst_valid", {31'b0, valid}, 32'd0);
        check_eq("t6_rst_inst", inst, NOP);
        check_eq("t6_rst_added_pc", added_pc, 32'd0);
        tick();
        @(negedge clk);
        check_eq("t6_req", {31'b0, req}, 32'd1);
        check_eq("t6_addr", addr, RESET_PC);
        delivered = 0;
        wait_deliv(2, 40, "t6_deliv");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline; the producer side of the IF/ID interface.
- Owns the PC and issues requests to instruction memory over a req/ack handshake.
- Delivers {PC+4, instruction} pairs with a valid flag to the IF/ID register.
- Honours the hazard-unit stall; redirects on branch/jump, discarding stale in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INST, 32'h0000_0000, value on inst_o whenever inst_valid_o=0.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  synchronous reset, active-high.
- stall_i  in  1  hazard stall; consumer does not accept this cycle.
- branch_i  in  1  taken-branch redirect pulse.
- branch_target_i  in  32  branch target PC.
- jump_i  in  1  jump redirect pulse.
- jump_target_i  in  32  jump target PC.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  fetch address; stable while req is high and ack is low.
- imem_ack_i  in  1  one-cycle response strobe.
- imem_rdata_i  in  32  instruction; valid only with ack.
- addedPC_o  out  32  PC+4 of the delivered instruction.
- inst_o  out  32  delivered instruction.
- inst_valid_o  out  1  output slot holds a live instruction.

Behaviour:
- Reset (rst_i=1 at posedge):
  - pc=RESET_PC, state=IDLE, both buffer entries empty.
  - addedPC_o=0, inst_o=NOP_INST, inst_valid_o=0, imem_req_o=0.
  - Reset overrides every other input. The memory is reset by the same rst_i, so no stale ack appears after reset.
- States:
  - IDLE: req=0; unconditionally -> FETCH next cycle.
  - FETCH: req=1 iff skid entry is empty, or a request is already outstanding.
    - Once raised, req and addr stay asserted until ack, regardless of stall_i.
    - On ack: pc<=pc+4, and the next request may issue the following cycle (one fetch per 2 cycles minimum is NOT required; back-to-back allowed, latency ≥1).
  - DRAIN: entered on redirect while a request is outstanding without ack. req=0. On ack, rdata is discarded -> FETCH at the redirected pc.
- Output buffer (2 entries: out slot + skid):
  - Accept: consumer takes the out slot when inst_valid_o=1 and stall_i=0.
  - Ack with out slot empty or being accepted: data goes to the out slot, visible the next cycle with addedPC_o = request addr + 4.
  - Ack with out slot occupied and stall_i=1: data goes to skid. Skid moves to the out slot on the next accept.
  - Skid full blocks new requests, so no overflow is possible.
  - Order preserved; no loss, no duplication.
- Stall: outputs hold their value and valid bit. The PC advances only through acks.
- Redirect (branch_i or jump_i at posedge):
  - jump_i has priority over branch_i when both are high.
  - pc<=target.
  - Both buffer entries are flushed: next cycle addedPC_o=0, inst_o=NOP_INST, inst_valid_o=0.
  - Redirect overrides stall_i.
  - Ack in the same cycle as redirect: data discarded, no DRAIN, next request uses the target.
  - Outstanding request with no ack: -> DRAIN.
  - Redirect while already in DRAIN: pc updated to the new target, stays in DRAIN.
- Width rules: PC arithmetic is 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0. Low two PC bits are passed through unchecked.
- Latency: request issue -> ack (memory-defined, ≥1 cycle) -> outputs valid 1 cycle after ack.

Decomposition:
- Shared package cpu_pkg: WORD_W=32, PC_INC=4, NOP_INST constant, fetch state enum {IDLE, FETCH, DRAIN}.
- One natural sub-module: fetch_skid_buf.
  - 2-entry ordered buffer of {addedPC, inst}.
  - Inputs: push, accept, flush.
  - Outputs: out slot, valid, full.
- FSM and PC logic live in the top module.

Test Plan:
1. Reset held 2 cycles, then released -> IDLE 1 cycle, then imem_req_o=1 with addr=0; outputs 0/NOP/valid=0 throughout.
2. Memory acks 1 cycle after each req with rdata=addr^32'hA5A5_0000, no stall -> inst_o sequence A5A5_0000, A5A5_0004, A5A5_0008 with addedPC_o 4, 8, 12.
3. stall_i high 4 cycles while two acks arrive -> out slot holds addr-0 instruction, skid holds addr-4, req drops. After release: addr-0, addr-4, addr-8 delivered once each, in order.
4. branch_i with target 32'h100 while req to 0x8 is pending and ack is 2 cycles late -> DRAIN; 0x8 data never appears; next req addr=0x100; valid=0 until 0x100 data is delivered.
5. jump_i (target 0x400) and branch_i (target 0x200) in the same cycle as an ack -> ack data discarded; next req addr=0x400.
6. rst_i asserted mid-FETCH with stall_i=1 and skid full -> next cycle all outputs zero, valid=0, req=0; then req addr=RESET_PC.
